// File: rtl/alu_result_skid_pkg.sv
// Shared definitions for the ALU result skid buffer: widths, occupancy
// encodings and ALUcontrol tag codes.
package alu_result_skid_pkg;

  localparam int unsigned ALU_DATA_W  = 32;
  localparam int unsigned ALU_SEL_W   = 2;
  localparam int unsigned ALU_STALL_W = 16;

  // Buffer occupancy: nothing, main register only, main plus skid register
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // ALUcontrol codes carried as the result tag
  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } alu_sel_e;

endpackage

// File: rtl/alu_result_skid_if.sv
// Valid/ready result channel: data word, ALUcontrol tag and result flags.
// The producer side drives data/sel/valid (and flags); the consumer drives ready.
interface alu_result_skid_if
  import alu_result_skid_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned SEL_W  = ALU_SEL_W
);

  logic [DATA_W-1:0] data;
  logic [SEL_W-1:0]  sel;
  logic              valid;
  logic              ready;
  logic              zero;
  logic              neg;

  modport master (output data, sel, valid, zero, neg, input ready);
  modport slave  (input data, sel, valid, output ready);

endinterface

// File: rtl/alu_result_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/alu_result_skid.sv
// Two-entry registered skid buffer between the ALU result mux and writeback.
// Full throughput with a registered in_ready; counts back-pressure cycles.
// Optional feature: define ALU_FLAGS_EN to carry zero/negative flags with each result.
module alu_result_skid
  import alu_result_skid_pkg::*;
#(
  parameter int unsigned DATA_W  = ALU_DATA_W,
  parameter int unsigned SEL_W   = ALU_SEL_W,
  parameter int unsigned STALL_W = ALU_STALL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_skid_if.slave   up,
  alu_result_skid_if.master  dn,
  input  logic               clr_stats,
  output logic [STALL_W-1:0] stall_cnt
);

  occ_e              state_q, state_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              accept_c;
  logic              take_c;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid_in;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [SEL_W-1:0]  main_sel_q,  skid_sel_q;
  logic              stall_inc_c;

  assign accept_c    = up.valid & in_ready_q;
  assign take_c      = out_valid_q & dn.ready;
  assign stall_inc_c = out_valid_q & ~dn.ready;

  // Occupancy next-state and entry load selects
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (accept_c) begin
          state_d      = OCC_ONE;
          load_main_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (accept_c && take_c) begin
          load_main_in = 1'b1;
        end else if (accept_c) begin
          state_d      = OCC_FULL;
          load_skid_in = 1'b1;
        end else if (take_c) begin
          state_d      = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (take_c) begin
          state_d        = OCC_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // State register plus registered handshake outputs derived from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != OCC_FULL);
      out_valid_q <= (state_d != OCC_EMPTY);
    end
  end

  // Main and skid payload registers; main refills from skid on drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      if (load_main_in) begin
        main_data_q <= up.data;
        main_sel_q  <= up.sel;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_sel_q  <= skid_sel_q;
      end
      if (load_skid_in) begin
        skid_data_q <= up.data;
        skid_sel_q  <= up.sel;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic in_zero_c, in_neg_c;
  logic main_zero_q, main_neg_q, skid_zero_q, skid_neg_q;

  assign in_zero_c = (up.data == '0);
  assign in_neg_c  = up.data[DATA_W-1];

  // Flags computed at capture and moved alongside their result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_zero_q <= 1'b0;
      main_neg_q  <= 1'b0;
      skid_zero_q <= 1'b0;
      skid_neg_q  <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_zero_q <= in_zero_c;
        main_neg_q  <= in_neg_c;
      end else if (load_main_skid) begin
        main_zero_q <= skid_zero_q;
        main_neg_q  <= skid_neg_q;
      end
      if (load_skid_in) begin
        skid_zero_q <= in_zero_c;
        skid_neg_q  <= in_neg_c;
      end
    end
  end

  assign dn.zero = main_zero_q;
  assign dn.neg  = main_neg_q;
`else
  assign dn.zero = 1'b0;
  assign dn.neg  = 1'b0;
`endif

  assign up.ready = in_ready_q;
  assign dn.valid = out_valid_q;
  assign dn.data  = main_data_q;
  assign dn.sel   = main_sel_q;

  // Back-pressure cycle counter
  sat_counter #(
    .W (STALL_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_c),
    .clr   (clr_stats),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_alu_result_skid.sv
// Scoreboard bench for alu_result_skid: the driver issues results, a
// behavioural FIFO model predicts order, readiness and the stall count, and a
// negedge monitor compares the DUT against it.
module tb_alu_result_skid;
  import alu_result_skid_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 2;
  localparam int unsigned STW = 16;
  localparam int          STALL_MAX = (1 << STW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           clr_stats = 1'b0;
  logic [STW-1:0] stall_cnt;

  alu_result_skid_if #(.DATA_W(DW), .SEL_W(SW)) up ();
  alu_result_skid_if #(.DATA_W(DW), .SEL_W(SW)) dn ();

  assign up.zero = 1'b0;
  assign up.neg  = 1'b0;

  alu_result_skid #(
    .DATA_W  (DW),
    .SEL_W   (SW),
    .STALL_W (STW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (up),
    .dn        (dn),
    .clr_stats (clr_stats),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          z;
    logic          n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic ready_exp = 1'b0;
  int   stall_exp = 0;

  function automatic exp_t mk(input logic [DW-1:0] d, input logic [SW-1:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
`ifdef ALU_FLAGS_EN
    e.z = (d == 0);
    e.n = d[DW-1];
`else
    e.z = 1'b0;
    e.n = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare against the model, then advance the model for the coming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 64'(dn.valid), 64'd0);
      chk("rst_in_ready",  64'(up.ready), 64'd0);
      chk("rst_out_data",  64'(dn.data),  64'd0);
      chk("rst_out_sel",   64'(dn.sel),   64'd0);
      chk("rst_out_zero",  64'(dn.zero),  64'd0);
      chk("rst_out_neg",   64'(dn.neg),   64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      sb.delete();
      ready_exp = 1'b0;
      stall_exp = 0;
    end else begin
      int  occ;
      bit  take, accept;
      occ = sb.size();
      chk("out_valid", 64'(dn.valid), 64'(occ > 0));
      chk("in_ready",  64'(up.ready), 64'(ready_exp));
      chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
      if (occ > 0 && dn.valid) begin
        chk("out_data", 64'(dn.data), 64'(sb[0].d));
        chk("out_sel",  64'(dn.sel),  64'(sb[0].s));
        chk("out_zero", 64'(dn.zero), 64'(sb[0].z));
        chk("out_neg",  64'(dn.neg),  64'(sb[0].n));
      end
      take   = (occ > 0) && (dn.ready === 1'b1);
      accept = (up.valid === 1'b1) && ready_exp;
      if (take)   void'(sb.pop_front());
      if (accept) sb.push_back(mk(up.data, up.sel));
      if (clr_stats)
        stall_exp = 0;
      else if (occ > 0 && dn.ready !== 1'b1 && stall_exp < STALL_MAX)
        stall_exp++;
      ready_exp = (sb.size() < 2);
    end
  end

  // Offer one result and hold it until the buffer takes it
  task automatic push(input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n = 0;
    up.valid = 1'b1;
    up.data  = d;
    up.sel   = s;
    @(negedge clk);
    while (up.ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (up.ready !== 1'b1) chk("push_accept_timeout", 64'(up.ready), 64'd1);
    @(posedge clk);
    #1;
    up.valid = 1'b0;
  endtask

  // Let writeback consume everything the model still holds
  task automatic drain();
    int n = 0;
    dn.ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    up.valid = 1'b1;
    up.data  = 32'hDEAD_BEEF;
    up.sel   = 2'd3;
    dn.ready = 1'b0;

    // Reset held with in_valid high: nothing may be accepted
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", 64'(up.ready), 64'd1);
    chk("no_accept_in_reset",  64'(dn.valid), 64'd0);
    up.valid = 1'b0;
    @(posedge clk);
    #1;
    chk("no_accept_in_reset2", 64'(dn.valid), 64'd0);

    // Streaming at full rate
    dn.ready = 1'b1;
    push(32'h11, 2'd0);
    push(32'h22, 2'd1);
    push(32'h33, 2'd2);
    drain();

    // Back-pressure: fill both entries, hold a third word off
    dn.ready = 1'b0;
    push(32'hA, 2'd0);
    push(32'hB, 2'd1);
    @(negedge clk);
    chk("bp_full_in_ready", 64'(up.ready), 64'd0);
    chk("bp_head_data",     64'(dn.data),  64'hA);
    @(posedge clk);
    #1;
    up.valid = 1'b1;
    up.data  = 32'hC;
    up.sel   = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    dn.ready = 1'b1;
    push(32'hC, 2'd2);
    drain();

    // Stall counter saturation, then clear on a stall cycle
    dn.ready = 1'b0;
    push(32'h77, 2'd3);
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_saturated", 64'(stall_cnt), 64'hFFFF);
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    chk("stall_cleared", 64'(stall_cnt), 64'd0);
    drain();

    // Flag patterns
    dn.ready = 1'b1;
    push(32'h0000_0000, 2'd0);
    push(32'h8000_0000, 2'd1);
    push(32'h0000_0005, 2'd2);
    drain();

    // Randomised traffic
    repeat (3000) begin
      int unsigned r;
      @(posedge clk);
      #1;
      r = $urandom_range(0, 7);
      up.valid  = ($urandom_range(0, 2) != 0);
      up.data   = (r == 0) ? 32'd0 : (r == 1) ? (32'h8000_0000 | $urandom) : $urandom;
      up.sel    = 2'($urandom_range(0, 3));
      dn.ready  = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 63) == 0);
    end
    #0;
    up.valid  = 1'b0;
    clr_stats = 1'b0;
    drain();

    // Mid-operation reset pulse between edges while full
    dn.ready = 1'b0;
    push(32'h100, 2'd0);
    push(32'h200, 2'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(dn.valid),  64'd0);
    chk("midrst_in_ready",  64'(up.ready),  64'd0);
    chk("midrst_stall",     64'(stall_cnt), 64'd0);
    sb.delete();
    ready_exp = 1'b0;
    stall_exp = 0;
    #1 rst_n = 1'b1;
    dn.ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_stale", 64'(dn.valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
